pipelined_adder_seg: RTL and testbench

- Parametrised successor to the registered two-operand adder benchmark.
- Computes a+b or a-b over an arbitrary WIDTH by splitting the carry chain into SEG_WIDTH-bit segments, one segment per pipeline stage, so Fmax is independent of WIDTH.
- Adds valid/ready flow control, per-transaction add/sub mode and a carry/no-borrow flag.
- Used as the arithmetic benchmark kernel for adder-width/pipelining sweeps.

---
 rtl/pipelined_adder_seg.sv | 112 +++++++++++
 tb/tb_pipelined_adder_seg.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_seg.sv
// -----------------------------------------------------------------------------
// pipelined_adder_seg
//
// Purpose:
//   Unsigned WIDTH-bit adder/subtractor whose carry chain is cut into
//   SEG_WIDTH-bit segments, one segment per pipeline stage, so the critical
//   path is one SEG_WIDTH-bit add regardless of WIDTH. Valid/ready flow
//   control with a single global stall; latency is NUM_SEG+1 cycles.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   a/b/sub valid this cycle
//   in_ready   block accepts input this cycle (= !stall)
//   a, b       unsigned operands, WIDTH bits
//   sub        0: a+b, 1: a-b
//   out_valid  sum valid
//   out_ready  downstream accepts sum
//   sum        {carry-out, result}; for sub, carry-out=1 means no borrow
// -----------------------------------------------------------------------------
module pipelined_adder_seg #(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    localparam int NUM_SEG = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;

    logic               w_stall;
    logic [NUM_SEG-1:0] w_cout;

    // r_valid[k] / r_carry[k] belong to pipeline stage k. r_carry[0] is the
    // registered sub bit, which doubles as the carry-in of segment 0.
    logic [NUM_SEG:0]   r_valid;
    logic [NUM_SEG:0]   r_carry;

    assign w_stall   = r_valid[NUM_SEG] & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = r_valid[NUM_SEG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_carry <= '0;
        end else if (!w_stall) begin
            r_valid <= {r_valid[NUM_SEG-1:0], in_valid};
            r_carry <= {w_cout, sub};
        end
    end

    // One block per segment. Block gi holds the stage-gi operand registers
    // (only the bits from segment gi upward are still needed, so the operand
    // registers shrink as the pipe advances) and the stage-(gi+1) result
    // register, which grows to hold every segment computed so far.
    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_seg
        localparam int LO = gi * SEG_WIDTH;
        localparam int HI = ((gi + 1) * SEG_WIDTH > WIDTH) ? (WIDTH - 1)
                                                           : ((gi + 1) * SEG_WIDTH - 1);
        localparam int SW = HI - LO + 1;

        logic [WIDTH-1:LO] r_a;
        logic [WIDTH-1:LO] r_b;
        logic [HI:0]       r_res;
        logic [SW:0]       w_seg;

        // Segment add; the ragged last segment simply has SW < SEG_WIDTH and
        // its carry comes out of bit WIDTH-1.
        assign w_seg      = {1'b0, r_a[HI:LO]} + {1'b0, r_b[HI:LO]} + {{SW{1'b0}}, r_carry[gi]};
        assign w_cout[gi] = w_seg[SW];

        if (gi == 0) begin : g_first
            // Input register: b is pre-inverted for subtract, the +1 comes
            // in through the segment-0 carry.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_res <= '0;
                end else if (!w_stall) begin
                    r_a   <= a;
                    r_b   <= b ^ {WIDTH{sub}};
                    r_res <= w_seg[SW-1:0];
                end
            end
        end else begin : g_next
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_res <= '0;
                end else if (!w_stall) begin
                    r_a   <= g_seg[gi-1].r_a[WIDTH-1:LO];
                    r_b   <= g_seg[gi-1].r_b[WIDTH-1:LO];
                    r_res <= {w_seg[SW-1:0], g_seg[gi-1].r_res};
                end
            end
        end
    end

    assign sum = {r_carry[NUM_SEG], g_seg[NUM_SEG-1].r_res};

endmodule

// File: tb/tb_pipelined_adder_seg.sv
module tb_pipelined_adder_seg;

    logic clk;
    logic reset;

    // WIDTH=8, SEG_WIDTH=3 (NUM_SEG=3, ragged last segment)
    logic       v8, rdy8, s8, ov8, or8;
    logic [7:0] a8, b8;
    logic [8:0] sum8;

    // defaults: WIDTH=32, SEG_WIDTH=8 (NUM_SEG=4)
    logic        v32, rdy32, s32, ov32, or32;
    logic [31:0] a32, b32;
    logic [32:0] sum32;

    // WIDTH=8, SEG_WIDTH=8 (NUM_SEG=1)
    logic       v1, rdy1, s1, ov1, or1;
    logic [7:0] a1, b1;
    logic [8:0] sum1;

    int errors = 0;
    int checks = 0;

    pipelined_adder_seg #(.WIDTH(8), .SEG_WIDTH(3)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8),
        .a(a8), .b(b8), .sub(s8), .out_valid(ov8), .out_ready(or8), .sum(sum8)
    );

    pipelined_adder_seg dut32 (
        .clk(clk), .reset(reset), .in_valid(v32), .in_ready(rdy32),
        .a(a32), .b(b32), .sub(s32), .out_valid(ov32), .out_ready(or32), .sum(sum32)
    );

    pipelined_adder_seg #(.WIDTH(8), .SEG_WIDTH(8)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v1), .in_ready(rdy1),
        .a(a1), .b(b1), .sub(s1), .out_valid(ov1), .out_ready(or1), .sum(sum1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned WIDTH+1 addition with two's-complement subtract.
    function automatic logic [32:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [32:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + 33'd1;
        else   r = {1'b0, x} + {1'b0, y};
        return r;
    endfunction

    task automatic test_reset;
        // load dut8 so its output stage is valid, then reset mid-cycle
        @(posedge clk); #1;
        v8 = 1'b1; a8 = 8'h03; b8 = 8'h04; s8 = 1'b0; or8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        v8 = 1'b0;
        checks++;
        if (ov8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_preload_valid: out_valid=%b expected 1", ov8);
        end
        checks++;
        if (sum8 !== 9'h007) begin
            errors++;
            $display("FAIL reset_preload_sum: sum=%h expected 007", sum8);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (ov8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_valid: out_valid=%b expected 0", ov8);
        end
        checks++;
        if (sum8 !== 9'h000) begin
            errors++;
            $display("FAIL reset_async_sum: sum=%h expected 000", sum8);
        end
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rdy8 !== 1'b1 || rdy32 !== 1'b1 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%b/%b/%b expected 1/1/1", rdy8, rdy32, rdy1);
        end
        checks++;
        if (ov8 !== 1'b0 || sum8 !== 9'h000) begin
            errors++;
            $display("FAIL reset_after_release: out_valid=%b sum=%h expected 0/000", ov8, sum8);
        end
        checks++;
        if (ov32 !== 1'b0 || sum32 !== 33'h0) begin
            errors++;
            $display("FAIL reset_dut32: out_valid=%b sum=%h expected 0/0", ov32, sum32);
        end
        $display("reset: in-flight dut8 results discarded");
    endtask

    // Two back-to-back transactions on dut8, results expected 4 and 5 cycles later.
    task automatic run8_pair(input string name,
                             input logic [7:0] xa0, input logic [7:0] xb0, input logic xs0, input logic [8:0] e0,
                             input logic [7:0] xa1, input logic [7:0] xb1, input logic xs1, input logic [8:0] e1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k >= 1) begin
                checks++;
                if (ov8 !== (k == 4 || k == 5)) begin
                    errors++;
                    $display("FAIL %s_valid_k%0d: out_valid=%b expected %b", name, k, ov8, (k == 4 || k == 5));
                end
                if (k == 4) begin
                    checks++;
                    if (sum8 !== e0) begin
                        errors++;
                        $display("FAIL %s_sum0: sum=%h expected %h", name, sum8, e0);
                    end
                    $display("%s: %h %s %h -> %h", name, xa0, xs0 ? "-" : "+", xb0, sum8);
                end
                if (k == 5) begin
                    checks++;
                    if (sum8 !== e1) begin
                        errors++;
                        $display("FAIL %s_sum1: sum=%h expected %h", name, sum8, e1);
                    end
                    $display("%s: %h %s %h -> %h", name, xa1, xs1 ? "-" : "+", xb1, sum8);
                end
            end
            if (k == 0) begin v8 = 1'b1; a8 = xa0; b8 = xb0; s8 = xs0; end
            else if (k == 1) begin a8 = xa1; b8 = xb1; s8 = xs1; end
            else v8 = 1'b0;
        end
    endtask

    task automatic test_ragged_carry;
        or8 = 1'b1;
        run8_pair("carry", 8'hFF, 8'h01, 1'b0, 9'h100, 8'h0F, 8'h01, 1'b0, 9'h010);
    endtask

    task automatic test_subtract;
        or8 = 1'b1;
        run8_pair("sub", 8'h05, 8'h07, 1'b1, 9'h0FE, 8'h07, 8'h05, 1'b1, 9'h102);
    endtask

    task automatic test_single_segment;
        or1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k >= 1) begin
                checks++;
                if (ov1 !== (k == 2 || k == 3)) begin
                    errors++;
                    $display("FAIL seg1_valid_k%0d: out_valid=%b expected %b", k, ov1, (k == 2 || k == 3));
                end
            end
            if (k == 2) begin
                checks++;
                if (sum1 !== 9'h100) begin
                    errors++;
                    $display("FAIL seg1_sum0: sum=%h expected 100", sum1);
                end
                $display("seg1: 80 + 80 -> %h", sum1);
            end
            if (k == 3) begin
                checks++;
                if (sum1 !== 9'h0FF) begin
                    errors++;
                    $display("FAIL seg1_sum1: sum=%h expected 0FF", sum1);
                end
                $display("seg1: 00 - 01 -> %h", sum1);
            end
            if (k == 0) begin v1 = 1'b1; a1 = 8'h80; b1 = 8'h80; s1 = 1'b0; end
            else if (k == 1) begin a1 = 8'h00; b1 = 8'h01; s1 = 1'b1; end
            else v1 = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ta [100];
        logic [31:0] tb [100];
        logic        ts [100];
        logic [32:0] ex [100];
        int          got = 0;
        for (int i = 0; i < 100; i++) begin
            ta[i] = $urandom;
            tb[i] = $urandom;
            ts[i] = 1'($urandom_range(0, 1));
            ex[i] = ref32(ta[i], tb[i], ts[i]);
        end
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h0000_0001; ts[0] = 1'b0; ex[0] = 33'h1_0000_0000;
        ta[1] = 32'h0000_0000; tb[1] = 32'h0000_0001; ts[1] = 1'b1; ex[1] = 33'h0_FFFF_FFFF;
        or32 = 1'b1;
        for (int k = 0; k < 108; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ov32 !== (k >= 5 && k < 105)) begin
                errors++;
                $display("FAIL b2b_valid_k%0d: out_valid=%b expected %b", k, ov32, (k >= 5 && k < 105));
            end
            if (k >= 5 && k < 105) begin
                checks++;
                if (sum32 !== ex[k-5]) begin
                    errors++;
                    $display("FAIL b2b_sum_%0d: sum=%h expected %h", k - 5, sum32, ex[k-5]);
                end
                else got++;
                $display("b2b %0d: %h %s %h -> %h", k - 5, ta[k-5], ts[k-5] ? "-" : "+", tb[k-5], sum32);
            end
            if (k < 100) begin
                v32 = 1'b1; a32 = ta[k]; b32 = tb[k]; s32 = ts[k];
            end else v32 = 1'b0;
        end
        checks++;
        if (got != 100) begin
            errors++;
            $display("FAIL b2b_count: matched=%0d expected 100", got);
        end
    endtask

    task automatic test_backpressure;
        logic [32:0] q [$];
        logic [32:0] held;
        logic [31:0] ta [10];
        logic [31:0] tb [10];
        logic        ts [10];
        logic [32:0] e;
        int          idx = 0;
        int          emitted = 0;
        for (int i = 0; i < 10; i++) begin
            ta[i] = $urandom; tb[i] = $urandom; ts[i] = 1'($urandom_range(0, 1));
        end
        held = '0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            v32 = (idx < 10);
            if (idx < 10) begin a32 = ta[idx]; b32 = tb[idx]; s32 = ts[idx]; end
            or32 = !(k >= 6 && k <= 8);
            #1;
            if (k == 6) begin
                checks++;
                if (ov32 !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_valid_at_stall: out_valid=%b expected 1", ov32);
                end
                held = sum32;
            end
            if (k >= 6 && k <= 8) begin
                checks++;
                if (rdy32 !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready_k%0d: in_ready=%b expected 0", k, rdy32);
                end
            end
            if (k == 7 || k == 8) begin
                checks++;
                if (ov32 !== 1'b1 || sum32 !== held) begin
                    errors++;
                    $display("FAIL bp_hold_k%0d: out_valid=%b sum=%h expected 1/%h", k, ov32, sum32, held);
                end
            end
            if (ov32 && or32) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_extra: unexpected sum=%h", sum32);
                end
                else begin
                    e = q.pop_front();
                    if (sum32 !== e) begin
                        errors++;
                        $display("FAIL bp_sum_%0d: sum=%h expected %h", emitted, sum32, e);
                    end
                    $display("bp %0d: -> %h", emitted, sum32);
                end
                emitted++;
            end
            if (v32 && rdy32) begin
                q.push_back(ref32(ta[idx], tb[idx], ts[idx]));
                idx++;
            end
        end
        v32 = 1'b0;
        or32 = 1'b1;
        checks++;
        if (emitted != 10 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_count: emitted=%0d pending=%0d expected 10/0", emitted, q.size());
        end
    endtask

    task automatic test_reset_midstream;
        or32 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            v32 = 1'b1; a32 = 32'h100 + 32'(k); b32 = 32'h7; s32 = 1'b0;
        end
        @(posedge clk); #1;
        v32 = 1'b0;
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ov32 !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_flushed_k%0d: out_valid=%b expected 0", k, ov32);
            end
        end
        $display("reset midstream: 4 in-flight transactions discarded");
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            if (k >= 1) begin
                checks++;
                if (ov32 !== (k == 5)) begin
                    errors++;
                    $display("FAIL rst_mid_fresh_valid_k%0d: out_valid=%b expected %b", k, ov32, (k == 5));
                end
            end
            if (k == 5) begin
                checks++;
                if (sum32 !== 33'h2) begin
                    errors++;
                    $display("FAIL rst_mid_fresh_sum: sum=%h expected 2", sum32);
                end
                $display("fresh: 1 + 1 -> %h", sum32);
            end
            if (k == 0) begin v32 = 1'b1; a32 = 32'h1; b32 = 32'h1; s32 = 1'b0; end
            else v32 = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
        v32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0; or32 = 1'b1;
        v1 = 1'b0; a1 = '0; b1 = '0; s1 = 1'b0; or1 = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        test_reset();
        test_ragged_carry();
        test_subtract();
        test_single_segment();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
